// File: rtl/enc_8b10b_tx.sv
// enc_8b10b_tx: registered 8b/10b encoder with running disparity; optional RD force via ENC8B10B_RD_FORCE_EN
module enc_8b10b_tx #(
    parameter logic INIT_RD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    input  logic       k_in,
`ifdef ENC8B10B_RD_FORCE_EN
    input  logic       force_rd_valid,
    input  logic       force_rd,
`endif
    output logic       valid_out,
    output logic [9:0] data_out,
    output logic       rd_out,
    output logic       k_err
);
    logic [4:0] x;
    logic [2:0] y;
    logic       rd_q, rd_cur, rd6, rd_nxt, k28, k_ok, unbal6, a7, flip4;
    logic [5:0] c6, six;
    logic [3:0] c4, four;
    logic [9:0] sym;
    assign x = data_in[4:0];
    assign y = data_in[7:5];
    assign rd_out = rd_q;
    // RD- variant of the 5b/6b table; RD+ variants are the complement where they differ
    always_comb begin
        c6 = 6'b000000;
        case (x)
            5'd0:  c6 = 6'b100111;
            5'd1:  c6 = 6'b011101;
            5'd2:  c6 = 6'b101101;
            5'd3:  c6 = 6'b110001;
            5'd4:  c6 = 6'b110101;
            5'd5:  c6 = 6'b101001;
            5'd6:  c6 = 6'b011001;
            5'd7:  c6 = 6'b111000;
            5'd8:  c6 = 6'b111001;
            5'd9:  c6 = 6'b100101;
            5'd10: c6 = 6'b010101;
            5'd11: c6 = 6'b110100;
            5'd12: c6 = 6'b001101;
            5'd13: c6 = 6'b101100;
            5'd14: c6 = 6'b011100;
            5'd15: c6 = 6'b010111;
            5'd16: c6 = 6'b011011;
            5'd17: c6 = 6'b100011;
            5'd18: c6 = 6'b010011;
            5'd19: c6 = 6'b110010;
            5'd20: c6 = 6'b001011;
            5'd21: c6 = 6'b101010;
            5'd22: c6 = 6'b011010;
            5'd23: c6 = 6'b111010;
            5'd24: c6 = 6'b110011;
            5'd25: c6 = 6'b100110;
            5'd26: c6 = 6'b010110;
            5'd27: c6 = 6'b110110;
            5'd28: c6 = k28 ? 6'b001111 : 6'b001110;
            5'd29: c6 = 6'b101110;
            5'd30: c6 = 6'b011110;
            5'd31: c6 = 6'b101011;
            default: c6 = 6'b000000;
        endcase
    end
    // Sub-block selection, K handling and disparity of the assembled symbol
    always_comb begin
        rd_cur = rd_q;
`ifdef ENC8B10B_RD_FORCE_EN
        rd_cur = force_rd_valid ? force_rd : rd_q;
`endif
        k28 = k_in && x == 5'd28;
        k_ok = k28 || (k_in && y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
        unbal6 = $countones(c6) != 3;
        six = (rd_cur && (unbal6 || x == 5'd7)) ? ~c6 : c6;
        rd6 = rd_cur ^ unbal6;
        a7 = y == 3'd7 && (k_ok || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20))
                               || (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        c4 = y == 3'd0 ? 4'b1011 : y == 3'd1 ? 4'b1001 : y == 3'd2 ? 4'b0101 :
             y == 3'd3 ? 4'b1100 : y == 3'd4 ? 4'b1101 : y == 3'd5 ? 4'b1010 :
             y == 3'd6 ? 4'b0110 : a7 ? 4'b0111 : 4'b1110;
        // K.28 neutral 4b codes invert on the entry RD so the comma survives
        flip4 = (k28 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6)) ? rd_cur :
                rd6 && (y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7);
        four = flip4 ? ~c4 : c4;
        sym = {six, four};
        rd_nxt = $countones(sym) == 5 ? rd_cur : $countones(sym) > 5;
    end
    // Output register and running disparity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= 10'b0;
            k_err     <= 1'b0;
            rd_q      <= INIT_RD;
        end else begin
            valid_out <= valid_in;
            k_err     <= valid_in && k_in && !k_ok;
            if (valid_in) data_out <= sym;
            rd_q      <= valid_in ? rd_nxt : rd_cur;
        end
    end
endmodule

// File: tb/tb_enc_8b10b_tx.sv
// tb_enc_8b10b_tx: directed and randomized checks of enc_8b10b_tx against a table-driven reference
module tb_enc_8b10b_tx;
    logic       clk = 1'b0;
    logic       rst_n, valid_in, k_in, valid_out, rd_out, k_err;
    logic [7:0] data_in;
    logic [9:0] data_out;
    logic       force_rd_valid, force_rd;
    int         pass = 0, total = 0;
    logic       mrd, mke, fv, fr;
    logic [9:0] msym;

    logic [5:0] t6n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                             6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                             6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                             6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] t6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
                             6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
                             6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                             6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [9:0] k28n [8] = '{10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
                             10'b0011110010, 10'b0011111010, 10'b0011110110, 10'b0011111000};
    logic [9:0] k28p [8] = '{10'b1100001011, 10'b1100000110, 10'b1100001010, 10'b1100001100,
                             10'b1100001101, 10'b1100000101, 10'b1100001001, 10'b1100000111};
    logic [7:0] klist [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    enc_8b10b_tx #(.INIT_RD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .k_in(k_in),
`ifdef ENC8B10B_RD_FORCE_EN
        .force_rd_valid(force_rd_valid), .force_rd(force_rd),
`endif
        .valid_out(valid_out), .data_out(data_out), .rd_out(rd_out), .k_err(k_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic void model(input logic [7:0] b, input logic k, input logic r,
                                  output logic [9:0] s, output logic ke, output logic rn);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] six;
        logic [3:0] four;
        logic legal, r6, alt;
        x = b[4:0];
        y = b[7:5];
        legal = k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        if (legal && x == 28) s = r ? k28p[y] : k28n[y];
        else begin
            six = r ? t6p[x] : t6n[x];
            r6 = ($countones(six) == 3) ? r : ~r;
            alt = y == 7 && (legal || (!r6 && (x == 17 || x == 18 || x == 20)) || (r6 && (x == 11 || x == 13 || x == 14)));
            four = alt ? (r6 ? 4'b1000 : 4'b0111) : (r6 ? t4p[y] : t4n[y]);
            s = {six, four};
        end
        ke = k && !legal;
        rn = ($countones(s) == 5) ? r : ($countones(s) > 5);
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic k);
        logic [9:0] s;
        logic ke, rn;
        @(negedge clk);
        valid_in = v;
        data_in = d;
        k_in = k;
        force_rd_valid = fv;
        force_rd = fr;
        if (fv) mrd = fr;
        mke = 1'b0;
        if (v) begin
            model(d, k, mrd, s, ke, rn);
            msym = s;
            mrd = rn;
            mke = ke;
        end
        @(posedge clk);
        #1;
        chk("valid_out", valid_out, v);
        chk("k_err", k_err, mke);
        chk("data_out", data_out, msym);
        chk("rd_out", rd_out, mrd);
    endtask

    initial begin
        logic [7:0] b;
        logic k;
        int r;
        rst_n = 1'b0; valid_in = 1'b0; data_in = 8'h00; k_in = 1'b0;
        force_rd_valid = 1'b0; force_rd = 1'b0; fv = 1'b0; fr = 1'b0;
        mrd = 1'b0; mke = 1'b0; msym = 10'b0;
        #12;
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_kerr", k_err, 0);
        chk("rst_rd", rd_out, 0);
        @(negedge clk) rst_n = 1'b1;
        step(1, 8'h00, 0); chk("d0.0", data_out, 10'b1001110100);
        step(1, 8'hBC, 1); chk("k28.5n", data_out, 10'b0011111010); chk("k28.5n_rd", rd_out, 1);
        step(1, 8'hBC, 1); chk("k28.5p", data_out, 10'b1100000101); chk("k28.5p_rd", rd_out, 0);
        step(1, 8'hB5, 0); chk("d21.5", data_out, 10'b1010101010); chk("d21.5_rd", rd_out, 0);
        step(1, 8'h07, 0); chk("d7.0n", data_out, 10'b1110001011); chk("d7.0n_rd", rd_out, 1);
        step(1, 8'hF1, 0); chk("d17.7p", data_out, 10'b1000110001); chk("d17.7p_rd", rd_out, 0);
        step(1, 8'hF1, 0); chk("d17.7n", data_out, 10'b1000110111); chk("d17.7n_rd", rd_out, 1);
        step(1, 8'h00, 1); chk("badk_err", k_err, 1); chk("badk_data", data_out, 10'b0110001011);
        step(1, 8'h07, 0); chk("d7.0p", data_out, 10'b0001110100);
        for (int i = 0; i < 3; i++) step(0, 8'h55, 0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            b = 8'($urandom);
            k = 1'b0;
            if (r < 10) begin
                b = klist[$urandom_range(0, 11)];
                k = 1'b1;
            end else if (r < 14 && b[7:5] != 3'd7 && b[4:0] != 5'd28) k = 1'b1;
            step($urandom_range(0, 99) < 80, b, k);
        end
        step(1, mrd ? 8'h00 : 8'h07, 0);
        chk("pre_rst_rd", rd_out, 1);
        @(negedge clk);
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_rd", rd_out, 0);
        @(negedge clk) rst_n = 1'b1;
        mrd = 1'b0;
        msym = 10'b0;
        step(1, 8'h00, 0); chk("post_rst", data_out, 10'b1001110100);
`ifdef ENC8B10B_RD_FORCE_EN
        fv = 1'b1; fr = 1'b1;
        step(1, 8'h00, 0); chk("force_data", data_out, 10'b0110001011); chk("force_rd", rd_out, 1);
        fv = 1'b0; fr = 1'b0;
        step(1, 8'h00, 0);
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
